video_pattern_gen: RTL and testbench
====================================

// Module: video_pattern_gen
// PURPOSE
//  Multi-mode NTSC composite test-pattern generator; successor to the single-pattern square/ramp source.
//  Consumes VIDEO_SQU_TG timing (counters, blank, sync, burst, sin/cos subcarrier) and emits parametrised-width composite video to the DAC.
//  Adds a runtime pattern-mode select with frame-boundary handshake, an auto-cycle mode and saturation reporting.
// PARAMETERS
//  C_VW          10    composite output width (bits)
//  C_PEDE        205   blank/pedestal level, C_VW-bit code
//  C_CSHIFT      5     chroma left-shift applied to the 5b signed sin/cos sum
//  C_AUTO_FRMS   60    frames per pattern when auto-cycling (1..255)
//  C_MODE_INIT   3'd4  mode loaded at reset
// PORTS
//  CK_i              in   1     pixel clock, 12.27272MHz
//  RST_i             in   1     synchronous reset, active high
//  CK_EE_i           in   1     clock enable; all state advances only when high
//  HCTRs_i           in   10    horizontal pixel counter from TG
//  VCTRs_i           in   9     line counter from TG (0..262)
//  FCTRs_i           in   8     frame counter from TG
//  XBLK_i            in   1     active-low blanking
//  XSYNC_i           in   1     active-low sync
//  CBURST_i          in   1     colour-burst window
//  sin_s_i, cos_s_i  in   4     signed subcarrier samples
//  MODE_REQ_i        in   3     requested pattern mode
//  MODE_REQ_VALID_i  in   1     request valid
//  MODE_REQ_READY_o  out  1     request accepted when VALID&READY on an enabled cycle
//  AUTO_i            in   1     1 = auto-cycle modes 0..5
//  MODEs_o           out  3     mode currently being drawn
//  VIDEOs_o          out  C_VW  composite sample
//  CLIP_o            out  1     one-cycle pulse: active sample saturated
// BEHAVIOUR
//  Reset: VIDEOs_o=C_PEDE, MODEs_o=C_MODE_INIT, MODE_REQ_READY_o=0, CLIP_o=0, auto frame counter=0, FSM=IDLE.
//  Frame start FS = CK_EE_i & HCTRs_i==0 & VCTRs_i==0.
//  Mode FSM: IDLE (READY=1) -VALID&READY-> PEND (capture MODE_REQ_i, READY=0) -FS-> IDLE, MODEs_o<=captured.
//   Request accepted and FS on the same cycle: new mode applies at the NEXT FS (no mid-frame change, ever).
//   Accepted request clears the auto frame counter.
//  Auto: AUTO_i=1 and IDLE: count FS; at C_AUTO_FRMS-th FS MODEs_o<=(MODEs_o==5)?0:MODEs_o+1, counter<=0.
//   PEND has priority over auto advance. AUTO_i=0 freezes the counter (not cleared).
//  Modes (luma Y in C_VW+2b signed, chroma C=sum<<<C_CSHIFT, sign-extended):
//   0 flat: Y=C_PEDE+(max-C_PEDE)/2, C=0
//   1 ramp: Y=C_PEDE+((HCTRs_i[9:1]+VCTRs_i+FCTRs_i) mod 256)<<(C_VW-9), C=0
//   2 hue wheel: C from 8 sectors HCTRs_i[8:6] (+cos,+cos-sin,-sin,-cos-sin,-cos,-cos+sin,+sin,+cos+sin), Y=C_PEDE+(max-C_PEDE)/2
//   3 crosshatch: white (max) where HCTRs_i[4:0]==0 or VCTRs_i[4:0]==0, else C_PEDE; C=0
//   4 75% bars: 8 bars by HCTRs_i[8:6], fixed luma/chroma table in package
//   5 checker: HCTRs_i[5]^VCTRs_i[5]^FCTRs_i[5] ? max : C_PEDE
//   6,7: C_PEDE (reserved, accepted, not auto-visited)
//  Priority per sample: ~XSYNC_i ->0; CBURST_i ->C_PEDE+((-cos_s_i)<<<C_CSHIFT); ~XBLK_i ->C_PEDE; else S=Y+C.
//  Saturation: S<0 ->0, S>2^C_VW-1 ->all ones; CLIP_o=1 same cycle VIDEOs_o carries a clipped active sample.
//  Latency: fixed 2 enabled cycles, all inputs (incl. sync/blank) to VIDEOs_o; stage1 Y/C, stage2 sum/select/clip.
//  CK_EE_i=0: every register (pipeline, FSM, counters) holds; CLIP_o holds 0.
//  RST_i mid-frame: pending request dropped, mode -> C_MODE_INIT, output pedestal next cycle.
// STRUCTURE
//  Package video_pattern_pkg: mode enum (MODE_FLAT..MODE_CHECK), bar luma/chroma-select table, chroma sector fn.
//  One sub-module: video_pattern_modefsm (handshake, FS detect, auto counter) -> MODEs_o.
//  Top: two-stage datapath, saturation, output mux.
// TESTING
//  Reset 4 cycles, XSYNC_i=0 -> VIDEOs_o=0 two cycles after reset release; MODEs_o=4, READY=1.
//  REQ=1 VALID mid-frame -> READY low next cycle; MODEs_o stays 4 until FS, becomes 1 at FS; READY back to 1.
//  AUTO_i=1, C_AUTO_FRMS=2, from mode 5 -> 0 after 2 FS; request during auto clears count, request wins.
//  Mode 2, cos=+7 sin=-7, C_CSHIFT=5, active -> VIDEOs_o=C_PEDE+(max-C_PEDE)/2+448 clipped to 1023, CLIP_o=1.
//  CBURST_i=1 cos=+7 -> VIDEOs_o=205-224 clipped to 0; XBLK_i=0 -> 205 exactly 2 cycles later.
//  CK_EE_i toggled 1/0 random -> output stream identical to CK_EE_i=1 run with stalls removed.

Source files
------------

// File: rtl/video_pattern_pkg.sv
// rtl/video_pattern_pkg.sv - shared types, colour-bar table and chroma sector helper for the pattern generator
package video_pattern_pkg;

    typedef enum logic [2:0] {
        MODE_FLAT  = 3'd0,
        MODE_RAMP  = 3'd1,
        MODE_HUE   = 3'd2,
        MODE_HATCH = 3'd3,
        MODE_BARS  = 3'd4,
        MODE_CHECK = 3'd5,
        MODE_RSV6  = 3'd6,
        MODE_RSV7  = 3'd7
    } mode_e;

    typedef enum logic {
        FSM_IDLE = 1'b0,
        FSM_PEND = 1'b1
    } fsm_e;

    typedef enum logic [1:0] {
        KIND_SYNC   = 2'd0,
        KIND_BURST  = 2'd1,
        KIND_BLANK  = 2'd2,
        KIND_ACTIVE = 2'd3
    } kind_e;

    // frac is bar luma as a fraction (/256) of the pedestal-to-white span
    typedef struct packed {
        logic [7:0] frac;
        logic       chroma_en;
        logic [2:0] sector;
    } bar_t;

    function automatic bar_t bar_lookup(input logic [2:0] idx);
        bar_t b;
        case (idx)
            3'd0:    b = '{frac: 8'd192, chroma_en: 1'b0, sector: 3'd0};
            3'd1:    b = '{frac: 8'd170, chroma_en: 1'b1, sector: 3'd4};
            3'd2:    b = '{frac: 8'd134, chroma_en: 1'b1, sector: 3'd2};
            3'd3:    b = '{frac: 8'd113, chroma_en: 1'b1, sector: 3'd3};
            3'd4:    b = '{frac: 8'd79,  chroma_en: 1'b1, sector: 3'd7};
            3'd5:    b = '{frac: 8'd58,  chroma_en: 1'b1, sector: 3'd6};
            3'd6:    b = '{frac: 8'd22,  chroma_en: 1'b1, sector: 3'd0};
            default: b = '{frac: 8'd0,   chroma_en: 1'b0, sector: 3'd0};
        endcase
        return b;
    endfunction

    // Sum wraps in 5 bits, matching the narrow adder the subcarrier path uses
    function automatic logic signed [4:0] chroma_sector(input logic [2:0] sector,
                                                        input logic signed [3:0] sin_s,
                                                        input logic signed [3:0] cos_s);
        logic signed [4:0] s5;
        logic signed [4:0] c5;
        logic signed [4:0] r;
        s5 = {sin_s[3], sin_s};
        c5 = {cos_s[3], cos_s};
        case (sector)
            3'd0:    r = c5;
            3'd1:    r = c5 - s5;
            3'd2:    r = -s5;
            3'd3:    r = -c5 - s5;
            3'd4:    r = -c5;
            3'd5:    r = s5 - c5;
            3'd6:    r = s5;
            default: r = c5 + s5;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/video_pattern_modefsm.sv
// rtl/video_pattern_modefsm.sv - mode request handshake, frame-start detect and auto-cycle counter
module video_pattern_modefsm
    import video_pattern_pkg::*;
#(
    parameter int          C_AUTO_FRMS = 60,
    parameter logic [2:0]  C_MODE_INIT = 3'd4
) (
    input  logic       ck_i,
    input  logic       rst_i,
    input  logic       ce_i,
    input  logic [9:0] hctr_i,
    input  logic [8:0] vctr_i,
    input  logic [2:0] req_mode_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       auto_i,
    output logic [2:0] mode_o,
    output logic [2:0] mode_next_o
);

    fsm_e       state_q;
    logic       ready_q;
    logic [2:0] mode_q;
    logic [2:0] mode_d;
    logic [2:0] cap_q;
    logic [7:0] cnt_q;
    logic       fs;
    logic       accept;
    logic       auto_hit;

    always_comb begin
        fs       = ce_i && (hctr_i == 10'd0) && (vctr_i == 9'd0);
        accept   = ce_i && req_valid_i && ready_q && (state_q == FSM_IDLE);
        auto_hit = auto_i && fs && (({1'b0, cnt_q} + 9'd1) == 9'(C_AUTO_FRMS));
    end

    // Next mode is exported so the pixel sampled on the frame-start edge already uses it
    always_comb begin
        mode_d = mode_q;
        if (ce_i) begin
            if (state_q == FSM_PEND) begin
                if (fs) begin
                    mode_d = cap_q;
                end
            end else if (!accept && auto_hit) begin
                mode_d = (mode_q == 3'd5) ? 3'd0 : mode_q + 3'd1;
            end
        end
    end

    always_ff @(posedge ck_i) begin
        if (rst_i) begin
            state_q <= FSM_IDLE;
            ready_q <= 1'b0;
            mode_q  <= C_MODE_INIT;
            cap_q   <= C_MODE_INIT;
            cnt_q   <= 8'd0;
        end else if (ce_i) begin
            mode_q <= mode_d;
            case (state_q)
                FSM_IDLE: begin
                    if (accept) begin
                        cap_q   <= req_mode_i;
                        state_q <= FSM_PEND;
                        ready_q <= 1'b0;
                        cnt_q   <= 8'd0;
                    end else begin
                        ready_q <= 1'b1;
                        if (auto_i && fs) begin
                            cnt_q <= auto_hit ? 8'd0 : cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    if (fs) begin
                        state_q <= FSM_IDLE;
                        ready_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign mode_o      = mode_q;
    assign mode_next_o = mode_d;

endmodule

// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - multi-mode NTSC composite test-pattern generator, two-stage datapath
module video_pattern_gen
    import video_pattern_pkg::*;
#(
    parameter int         C_VW        = 10,
    parameter int         C_PEDE      = 205,
    parameter int         C_CSHIFT    = 5,
    parameter int         C_AUTO_FRMS = 60,
    parameter logic [2:0] C_MODE_INIT = 3'd4
) (
    input  logic                   CK_i,
    input  logic                   RST_i,
    input  logic                   CK_EE_i,
    input  logic [9:0]             HCTRs_i,
    input  logic [8:0]             VCTRs_i,
    input  logic [7:0]             FCTRs_i,
    input  logic                   XBLK_i,
    input  logic                   XSYNC_i,
    input  logic                   CBURST_i,
    input  logic signed [3:0]      sin_s_i,
    input  logic signed [3:0]      cos_s_i,
    input  logic [2:0]             MODE_REQ_i,
    input  logic                   MODE_REQ_VALID_i,
    output logic                   MODE_REQ_READY_o,
    input  logic                   AUTO_i,
    output logic [2:0]             MODEs_o,
    output logic [C_VW-1:0]        VIDEOs_o,
    output logic                   CLIP_o
);

    localparam int W      = C_VW + 2;
    localparam int MAX_I  = (2 ** C_VW) - 1;
    localparam int SPAN_I = MAX_I - C_PEDE;
    localparam int MID_I  = C_PEDE + SPAN_I / 2;

    localparam logic signed [W-1:0] PEDE_S = W'(C_PEDE);
    localparam logic signed [W-1:0] MAX_S  = W'(MAX_I);
    localparam logic signed [W-1:0] MID_S  = W'(MID_I);
    localparam logic signed [W:0]   MAX_S1 = (W+1)'(MAX_I);

    logic [2:0] mode_draw;

    video_pattern_modefsm #(
        .C_AUTO_FRMS (C_AUTO_FRMS),
        .C_MODE_INIT (C_MODE_INIT)
    ) u_modefsm (
        .ck_i        (CK_i),
        .rst_i       (RST_i),
        .ce_i        (CK_EE_i),
        .hctr_i      (HCTRs_i),
        .vctr_i      (VCTRs_i),
        .req_mode_i  (MODE_REQ_i),
        .req_valid_i (MODE_REQ_VALID_i),
        .req_ready_o (MODE_REQ_READY_o),
        .auto_i      (AUTO_i),
        .mode_o      (MODEs_o),
        .mode_next_o (mode_draw)
    );

    function automatic logic signed [W-1:0] chroma_ext(input logic signed [4:0] v);
        return $signed({{(W-5){v[4]}}, v}) <<< C_CSHIFT;
    endfunction

    kind_e                kind_d, kind_q;
    logic signed [W-1:0]  y_d, y_q;
    logic signed [W-1:0]  c_d, c_q;
    logic signed [W-1:0]  pat_y, pat_c;
    logic [8:0]           ramp_sum;
    logic signed [4:0]    hue_sum, bar_sum, burst_neg;
    bar_t                 bar_c;
    logic [W+7:0]         bar_prod;
    logic                 hatch_on, check_on;

    // Stage 1: pattern luma/chroma and the sync/burst/blank classification
    always_comb begin
        ramp_sum  = HCTRs_i[9:1] + VCTRs_i + {1'b0, FCTRs_i};
        hue_sum   = chroma_sector(HCTRs_i[8:6], sin_s_i, cos_s_i);
        bar_c     = bar_lookup(HCTRs_i[8:6]);
        bar_sum   = chroma_sector(bar_c.sector, sin_s_i, cos_s_i);
        bar_prod  = (W+8)'(bar_c.frac) * (W+8)'(SPAN_I);
        burst_neg = -{cos_s_i[3], cos_s_i};
        hatch_on  = (HCTRs_i[4:0] == 5'd0) || (VCTRs_i[4:0] == 5'd0);
        check_on  = HCTRs_i[5] ^ VCTRs_i[5] ^ FCTRs_i[5];

        pat_y = PEDE_S;
        pat_c = '0;
        case (mode_e'(mode_draw))
            MODE_FLAT:  pat_y = MID_S;
            MODE_RAMP:  pat_y = PEDE_S + ($signed({{(W-8){1'b0}}, ramp_sum[7:0]}) <<< (C_VW - 9));
            MODE_HUE: begin
                pat_y = MID_S;
                pat_c = chroma_ext(hue_sum);
            end
            MODE_HATCH: pat_y = hatch_on ? MAX_S : PEDE_S;
            MODE_BARS: begin
                pat_y = PEDE_S + $signed(W'(bar_prod >> 8));
                pat_c = bar_c.chroma_en ? chroma_ext(bar_sum) : '0;
            end
            MODE_CHECK: pat_y = check_on ? MAX_S : PEDE_S;
            default:    pat_y = PEDE_S;
        endcase

        kind_d = KIND_ACTIVE;
        y_d    = pat_y;
        c_d    = pat_c;
        if (!XSYNC_i) begin
            kind_d = KIND_SYNC;
            y_d    = '0;
            c_d    = '0;
        end else if (CBURST_i) begin
            kind_d = KIND_BURST;
            y_d    = PEDE_S;
            c_d    = chroma_ext(burst_neg);
        end else if (!XBLK_i) begin
            kind_d = KIND_BLANK;
            y_d    = PEDE_S;
            c_d    = '0;
        end
    end

    logic signed [W:0]  sum_c;
    logic [C_VW-1:0]    video_d, video_q;
    logic               clip_d, clip_q;
    logic               sat;

    // Stage 2: sum, saturate; only active picture samples report clipping
    always_comb begin
        sum_c   = $signed({y_q[W-1], y_q}) + $signed({c_q[W-1], c_q});
        sat     = 1'b0;
        video_d = sum_c[C_VW-1:0];
        if (sum_c < 0) begin
            video_d = '0;
            sat     = 1'b1;
        end else if (sum_c > MAX_S1) begin
            video_d = '1;
            sat     = 1'b1;
        end
        clip_d = sat && (kind_q == KIND_ACTIVE);
    end

    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            kind_q  <= KIND_BLANK;
            y_q     <= PEDE_S;
            c_q     <= '0;
            video_q <= C_VW'(C_PEDE);
            clip_q  <= 1'b0;
        end else if (CK_EE_i) begin
            kind_q  <= kind_d;
            y_q     <= y_d;
            c_q     <= c_d;
            video_q <= video_d;
            clip_q  <= clip_d;
        end else begin
            clip_q  <= 1'b0;
        end
    end

    assign VIDEOs_o = video_q;
    assign CLIP_o   = clip_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb/tb_video_pattern_gen.sv - randomized and directed self-checking bench for video_pattern_gen
module tb_video_pattern_gen;

    logic              ck = 1'b0;
    logic              rst, ce;
    logic [9:0]        h;
    logic [8:0]        v;
    logic [7:0]        f;
    logic              xblk, xsync, cburst;
    logic signed [3:0] sn, cs;
    logic [2:0]        req;
    logic              valid, auto_m;
    logic              ready;
    logic [2:0]        mode_o;
    logic [9:0]        video;
    logic              clip;

    int total = 0;
    int bad   = 0;

    always #5 ck = ~ck;

    video_pattern_gen #(.C_AUTO_FRMS(2)) dut (
        .CK_i             (ck),
        .RST_i            (rst),
        .CK_EE_i          (ce),
        .HCTRs_i          (h),
        .VCTRs_i          (v),
        .FCTRs_i          (f),
        .XBLK_i           (xblk),
        .XSYNC_i          (xsync),
        .CBURST_i         (cburst),
        .sin_s_i          (sn),
        .cos_s_i          (cs),
        .MODE_REQ_i       (req),
        .MODE_REQ_VALID_i (valid),
        .MODE_REQ_READY_o (ready),
        .AUTO_i           (auto_m),
        .MODEs_o          (mode_o),
        .VIDEOs_o         (video),
        .CLIP_o           (clip)
    );

    localparam int PEDE = 205;
    localparam int VMAX = 1023;
    localparam int MID  = PEDE + (VMAX - PEDE) / 2;
    localparam int SPAN = VMAX - PEDE;
    int bar_frac [8] = '{192, 170, 134, 113, 79, 58, 22, 0};
    int bar_cen  [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    int bar_sec  [8] = '{0, 4, 2, 3, 7, 6, 0, 0};

    int m_mode, m_pend, m_cap, m_ready, m_cnt;
    int exp_v[$];
    int exp_c[$];
    int last_v, last_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int wrap5(input int x);
        return ((x + 16) & 31) - 16;
    endfunction

    function automatic int hue(input int sec, input int s, input int c);
        case (sec)
            0: return wrap5(c);
            1: return wrap5(c - s);
            2: return wrap5(-s);
            3: return wrap5(-c - s);
            4: return wrap5(-c);
            5: return wrap5(s - c);
            6: return wrap5(s);
            default: return wrap5(c + s);
        endcase
    endfunction

    function automatic int clamp(input int s);
        return (s < 0) ? 0 : ((s > VMAX) ? VMAX : s);
    endfunction

    task automatic ref_sample(input int mode, output int vid, output int clp);
        int hh, vv, ff, sv, cv, y, c, s, bar;
        hh = int'(h); vv = int'(v); ff = int'(f);
        sv = int'(sn); cv = int'(cs);
        bar = (hh / 64) % 8;
        y = PEDE; c = 0;
        case (mode)
            0: y = MID;
            1: y = PEDE + (((hh / 2) + vv + ff) % 256) * 2;
            2: begin y = MID; c = hue(bar, sv, cv) * 32; end
            3: y = ((hh % 32 == 0) || (vv % 32 == 0)) ? VMAX : PEDE;
            4: begin
                y = PEDE + bar_frac[bar] * SPAN / 256;
                c = bar_cen[bar] ? hue(bar_sec[bar], sv, cv) * 32 : 0;
            end
            5: y = ((((hh / 32) ^ (vv / 32) ^ (ff / 32)) & 1) != 0) ? VMAX : PEDE;
            default: y = PEDE;
        endcase
        clp = 0;
        if (!xsync) vid = 0;
        else if (cburst) vid = clamp(PEDE - cv * 32);
        else if (!xblk) vid = PEDE;
        else begin
            s = y + c;
            vid = clamp(s);
            clp = (s < 0 || s > VMAX) ? 1 : 0;
        end
    endtask

    task automatic model_fsm();
        bit fs;
        fs = (h == 0) && (v == 0);
        if (m_pend != 0) begin
            if (fs) begin m_mode = m_cap; m_pend = 0; m_ready = 1; end
        end else if (m_ready != 0 && valid) begin
            m_cap = int'(req); m_pend = 1; m_ready = 0; m_cnt = 0;
        end else begin
            m_ready = 1;
            if (auto_m && fs) begin
                m_cnt++;
                if (m_cnt == 2) begin
                    m_mode = (m_mode == 5) ? 0 : (m_mode + 1) % 8;
                    m_cnt = 0;
                end
            end
        end
    endtask

    task automatic tick();
        int ev, ec;
        @(posedge ck);
        if (rst) begin
            m_mode = 4; m_pend = 0; m_ready = 0; m_cnt = 0;
            exp_v.delete(); exp_c.delete();
            exp_v.push_back(PEDE); exp_c.push_back(0);
            last_v = PEDE; last_c = 0;
        end else if (ce) begin
            model_fsm();
            ref_sample(m_mode, ev, ec);
            exp_v.push_back(ev); exp_c.push_back(ec);
            last_v = exp_v.pop_front();
            last_c = exp_c.pop_front();
        end else begin
            last_c = 0;
        end
        #1;
        chk("video", video, last_v);
        chk("clip", clip, last_c);
        chk("mode", mode_o, m_mode);
        chk("ready", ready, m_ready);
    endtask

    task automatic fs_tick();
        h = 0; v = 0; tick();
        h = 3; v = 9;
    endtask

    initial begin
        rst = 1; ce = 1; xsync = 0; xblk = 1; cburst = 0;
        h = 100; v = 50; f = 0; sn = 0; cs = 0; req = 0; valid = 0; auto_m = 0;
        repeat (4) tick();
        chk("rst_mode", mode_o, 4);
        chk("rst_ready", ready, 0);
        chk("rst_video", video, PEDE);
        rst = 0;
        tick(); tick();
        chk("sync_zero", video, 0);
        chk("init_mode", mode_o, 4);
        chk("init_ready", ready, 1);

        xsync = 1; req = 1; valid = 1; tick();
        chk("ready_low", ready, 0);
        valid = 0; h = 200; tick(); tick();
        chk("mode_hold", mode_o, 4);
        fs_tick();
        chk("mode_switch", mode_o, 1);
        chk("ready_back", ready, 1);

        req = 5; valid = 1; tick(); valid = 0; fs_tick();
        chk("mode5", mode_o, 5);
        auto_m = 1;
        fs_tick(); tick();
        chk("auto_one_fs", mode_o, 5);
        fs_tick();
        chk("auto_wrap", mode_o, 0);
        fs_tick();
        req = 2; valid = 1; tick(); valid = 0;
        fs_tick();
        chk("req_wins", mode_o, 2);
        fs_tick();
        chk("cnt_cleared", mode_o, 2);
        fs_tick();
        chk("auto_adv", mode_o, 3);
        auto_m = 0;

        req = 2; valid = 1; tick(); valid = 0; fs_tick();
        h = 64; v = 10; cs = 7; sn = -7; tick(); tick();
        chk("hue_clip_video", video, 1023);
        chk("hue_clip_flag", clip, 1);
        cburst = 1; tick(); tick();
        chk("burst_video", video, 0);
        chk("burst_noclip", clip, 0);
        cburst = 0; xblk = 0; tick();
        tick();
        chk("blank_ped", video, PEDE);
        xblk = 1;

        req = 6; valid = 1; tick(); valid = 0; h = 300;
        rst = 1; tick(); rst = 0;
        chk("midrst_mode", mode_o, 4);
        chk("midrst_video", video, PEDE);
        chk("midrst_ready", ready, 0);

        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 1500; i++) begin
                ce     = (pass == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                h      = 10'($urandom_range(0, 779));
                v      = 9'($urandom_range(0, 262));
                f      = 8'($urandom);
                if ($urandom_range(0, 15) == 0) begin h = 0; v = 0; end
                xsync  = ($urandom_range(0, 9) != 0);
                cburst = ($urandom_range(0, 7) == 0);
                xblk   = ($urandom_range(0, 5) != 0);
                sn     = 4'($urandom);
                cs     = 4'($urandom);
                req    = 3'($urandom);
                valid  = ($urandom_range(0, 7) == 0);
                auto_m = ($urandom_range(0, 3) != 0);
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
